mux_sel_ctrl: RTL and testbench

Upstream control stage for the 3-bit 2:1 selector (`mux2_1`) on the lab development board. It synchronises two 3-bit switch banks into the selector's `in0`/`in1` data inputs. It also generates the selector's `cntrl` line from a debounced push-button that toggles the selection on each press, and from an optional free-running auto-alternate mode. All outputs are registered, so the downstream combinational selector sees glitch-free inputs.

---
 rtl/mux_sel_ctrl.sv | 112 +++++++++++
 tb/tb_mux_sel_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_ctrl
// Brief    : Synchronised data and debounced/auto-toggled select for mux2_1.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_ctrl #(
    parameter int DB_CYCLES   = 1000000,
    parameter int AUTO_PERIOD = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       auto_en,
    input  logic [2:0] sw_a,
    input  logic [2:0] sw_b,
    output logic [2:0] in0,
    output logic [2:0] in1,
    output logic       cntrl,
    output logic       sel_chg
);

    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int AUTO_W = $clog2(AUTO_PERIOD);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    // Bit layout of both synchroniser stages: {btn, auto_en, sw_a, sw_b}
    logic [7:0]        sync1_q;
    logic [7:0]        sync2_q;
    logic              btn_s;
    logic              auto_s;
    logic [2:0]        a_s;
    logic [2:0]        b_s;

    logic              db_level_q, db_level_d;
    logic [DB_W-1:0]   db_cnt_q,   db_cnt_d;
    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic              cntrl_q,    cntrl_d;
    logic              sel_chg_q,  sel_chg_d;
    logic [2:0]        in0_q;
    logic [2:0]        in1_q;
    logic              press;
    logic              tick;

    assign btn_s  = sync2_q[7];
    assign auto_s = sync2_q[6];
    assign a_s    = sync2_q[5:3];
    assign b_s    = sync2_q[2:0];

    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = db_cnt_q;
        auto_cnt_d = auto_cnt_q;
        press      = 1'b0;
        tick       = 1'b0;

        if (btn_s == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_level_d = btn_s;
            db_cnt_d   = '0;
            press      = btn_s;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end

        tick = auto_s && (auto_cnt_q == AUTO_LAST);

        // A press restarts the auto period; the wrap after a tick lands on 0 too.
        if (!auto_s || press || tick) begin
            auto_cnt_d = '0;
        end else begin
            auto_cnt_d = auto_cnt_q + AUTO_W'(1);
        end

        // Coincident press and tick cancel out.
        sel_chg_d = press ^ tick;
        cntrl_d   = cntrl_q ^ sel_chg_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            in0_q      <= '0;
            in1_q      <= '0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            auto_cnt_q <= '0;
            cntrl_q    <= 1'b0;
            sel_chg_q  <= 1'b0;
        end else begin
            sync1_q    <= {btn, auto_en, sw_a, sw_b};
            sync2_q    <= sync1_q;
            in0_q      <= a_s;
            in1_q      <= b_s;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            auto_cnt_q <= auto_cnt_d;
            cntrl_q    <= cntrl_d;
            sel_chg_q  <= sel_chg_d;
        end
    end

    assign in0     = in0_q;
    assign in1     = in1_q;
    assign cntrl   = cntrl_q;
    assign sel_chg = sel_chg_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_ctrl
// Brief    : Scoreboard bench for mux_sel_ctrl with a cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sel_ctrl;

    localparam int DB = 4;
    localparam int AP = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       auto_en;
    logic [2:0] sw_a;
    logic [2:0] sw_b;
    logic [2:0] in0;
    logic [2:0] in1;
    logic       cntrl;
    logic       sel_chg;

    always #5 clk = ~clk;

    mux_sel_ctrl #(
        .DB_CYCLES   (DB),
        .AUTO_PERIOD (AP)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .auto_en (auto_en),
        .sw_a    (sw_a),
        .sw_b    (sw_b),
        .in0     (in0),
        .in1     (in1),
        .cntrl   (cntrl),
        .sel_chg (sel_chg)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         n_tog = 0;
    logic       last_c = 1'b0;

    // Reference model state
    logic       m_btn_m, m_btn_s, m_auto_m, m_auto_s;
    logic [2:0] m_a_m, m_a_s, m_b_m, m_b_s;
    logic [2:0] m_in0, m_in1;
    logic       m_cntrl, m_selchg, m_lvl;
    int         m_cnt, m_acnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_btn_m = 0; m_btn_s = 0; m_auto_m = 0; m_auto_s = 0;
        m_a_m = 0; m_a_s = 0; m_b_m = 0; m_b_s = 0;
        m_in0 = 0; m_in1 = 0; m_cntrl = 0; m_selchg = 0; m_lvl = 0;
        m_cnt = 0; m_acnt = 0;
    endtask

    task automatic model_step();
        logic p, t;
        p = m_btn_s && !m_lvl && (m_cnt == DB - 1);
        t = m_auto_s && (m_acnt == AP - 1);
        m_in0    = m_a_s;
        m_in1    = m_b_s;
        m_selchg = p ^ t;
        m_cntrl  = m_cntrl ^ (p ^ t);
        if (!m_auto_s || p || t) m_acnt = 0;
        else                      m_acnt = m_acnt + 1;
        if (m_btn_s == m_lvl) m_cnt = 0;
        else if (m_cnt == DB - 1) begin
            m_lvl = m_btn_s;
            m_cnt = 0;
        end else m_cnt = m_cnt + 1;
        m_btn_s = m_btn_m;  m_btn_m = btn;
        m_auto_s = m_auto_m; m_auto_m = auto_en;
        m_a_s = m_a_m; m_a_m = sw_a;
        m_b_s = m_b_m; m_b_m = sw_b;
    endtask

    // One clock: predict, push, advance, pop and compare.
    task automatic run_cycle();
        logic [7:0] e;
        if (!rst_n) model_reset();
        else        model_step();
        exp_q.push_back({m_in0, m_in1, m_cntrl, m_selchg});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("outputs", {in0, in1, cntrl, sel_chg}, e);
        if (cntrl !== last_c) n_tog++;
        last_c = cntrl;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        int   n0;
        bit   found;
        logic b3 [10];

        rst_n = 1'b0; btn = 1'b0; auto_en = 1'b0; sw_a = '0; sw_b = '0;
        model_reset();
        #3;
        check_val("rst_out", {in0, in1, cntrl, sel_chg}, 8'h00);

        // 1. Reset and data path
        sw_a = 3'b101; sw_b = 3'b010;
        run_n(2);
        rst_n = 1'b1;
        run_n(4);
        check_val("t1_in0", in0, 5);
        check_val("t1_in1", in1, 2);
        check_val("t1_cntrl", cntrl, 0);
        for (int i = 0; i < 10; i++) begin
            sw_a = 3'($urandom_range(0, 7));
            sw_b = 3'($urandom_range(0, 7));
            run_cycle();
        end

        // 2. Clean press, release, second press
        btn = 1'b1; lat = -1; n0 = n_tog;
        for (int k = 1; k <= 20; k++) begin
            run_cycle();
            if (lat < 0 && n_tog != n0) lat = k;
        end
        check_val("t2_press_lat", lat - 1, 5);
        check_val("t2_cntrl", cntrl, 1);
        btn = 1'b0; run_n(10);
        btn = 1'b1; run_n(10);
        check_val("t2_second", cntrl, 0);
        btn = 1'b0; run_n(10);

        // 3. Bounce
        b3 = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        n0 = n_tog;
        for (int i = 0; i < 10; i++) begin
            btn = b3[i];
            run_cycle();
        end
        run_n(6);
        check_val("t3_toggles", n_tog - n0, 1);
        btn = 1'b0; run_n(10);
        check_val("t3_release", n_tog - n0, 1);

        // 4. Auto mode then freeze
        auto_en = 1'b1; n0 = n_tog;
        run_n(38);
        check_val("t4_toggles", n_tog - n0, 4);
        auto_en = 1'b0; n0 = n_tog;
        run_n(20);
        check_val("t4_freeze", n_tog - n0, 0);

        // 5. Press coinciding with auto_cnt = 7
        auto_en = 1'b1; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_auto_s && m_acnt == 2 && !m_lvl && !m_btn_s && m_cnt == 0) found = 1;
            else run_cycle();
        end
        check_val("t5_align", found, 1);
        btn = 1'b1; n0 = n_tog;
        run_n(6);
        check_val("t5_cancel", n_tog - n0, 0);
        check_val("t5_selchg", sel_chg, 0);
        run_n(7);
        check_val("t5_restart_hold", n_tog - n0, 0);
        run_cycle();
        check_val("t5_restart_tick", n_tog - n0, 1);
        auto_en = 1'b0; btn = 1'b0; run_n(10);

        // 6. Reset mid-count
        if (m_cntrl == 1'b0) begin
            btn = 1'b1; run_n(8);
            btn = 1'b0; run_n(8);
        end
        check_val("t6_pre_cntrl", cntrl, 1);
        btn = 1'b1; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_cnt == 2) found = 1;
            else run_cycle();
        end
        check_val("t6_align", found, 1);
        #3 rst_n = 1'b0;
        #1;
        check_val("t6_rst_cntrl", cntrl, 0);
        check_val("t6_rst_selchg", sel_chg, 0);
        model_reset();
        last_c = cntrl;
        run_n(2);
        rst_n = 1'b1; n0 = n_tog;
        run_n(5);
        check_val("t6_no_early", n_tog - n0, 0);
        run_cycle();
        check_val("t6_fresh", n_tog - n0, 1);
        btn = 1'b0; run_n(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
